// File: rtl/vx_serializer.sv
// vx_serializer: parallel-to-serial lane emitter.
// Accepts a bundle of N lane words plus an activity mask, then emits the
// active lanes one per beat in ascending lane order. Masked-off lanes are
// skipped without bubbles. The next bundle loads in the same cycle the
// final beat of the current bundle fires.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds in_valid/in_data/in_mask stable until
// in_ready is seen high; out_valid, once raised, stays high with
// out_data/out_idx/out_last unchanged until out_ready is seen high.
// in_ready depends combinationally on out_ready.
module vx_serializer #(
  parameter int DATAW = 1,
  parameter int N     = 4,
  parameter int LANEW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [N-1:0][DATAW-1:0]   in_data,
  input  logic [N-1:0]              in_mask,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [LANEW-1:0]          out_idx,
  output logic                      out_last,
  input  logic                      out_ready
);

  // Lane words of the bundle being emitted; only meaningful where the
  // pending mask has a bit set, so it carries no reset.
  logic [N-1:0][DATAW-1:0] pend_data;

  // One bit per lane still waiting to be emitted.
  logic [N-1:0]            pend_mask;

  // pend_mask with its lowest set bit cleared.
  logic [N-1:0]            mask_rest;
  logic [N-1:0]            mask_next;
  logic                    in_fire;
  logic                    out_fire;

  assign mask_rest = pend_mask & (pend_mask - N'(1));

  // Output status comes straight from the mask register.
  assign out_valid = |pend_mask;
  assign out_last  = out_valid && (mask_rest == '0);

  // A new bundle may load while the last beat of the current one leaves.
  assign in_ready  = !out_valid || (out_ready && out_last);

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Select the lowest pending lane: scan downwards so the lowest index wins.
  always_comb begin
    out_idx  = '0;
    out_data = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_mask[i]) begin
        out_idx  = LANEW'(i);
        out_data = pend_data[i];
      end
    end
  end

  // Next pending mask: a new bundle replaces the mask (the old one is
  // necessarily on its final beat), otherwise a fired beat retires its lane.
  always_comb begin
    mask_next = pend_mask;
    if (in_fire) begin
      mask_next = in_mask;
    end else if (out_fire) begin
      mask_next = mask_rest;
    end
  end

  // Pending mask register; reset wins over any simultaneous transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_mask <= '0;
    end else begin
      pend_mask <= mask_next;
    end
  end

  // Pending data register, captured only when a bundle is accepted.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      pend_data <= in_data;
    end
  end

endmodule

// File: tb/tb_vx_serializer.sv
// Testbench for vx_serializer: directed vectors on an N=4/DATAW=8 instance,
// then scoreboard runs with random masks and random out_ready at N=1,3,8.
module tb_vx_serializer;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic rand_go = 1'b0;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- directed DUT
  logic            in_valid;
  logic [3:0][7:0] in_data;
  logic [3:0]      in_mask;
  logic            in_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_idx;
  logic            out_last;
  logic            out_ready;

  vx_serializer #(.DATAW(8), .N(4)) u_dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  task automatic expect_beat(input string tag, input logic [7:0] d, input logic [1:0] idx,
                             input logic last);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".idx"},   32'(out_idx),   32'(idx));
    check({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".valid"},    32'(out_valid), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready),  32'd1);
  endtask

  // ---------------------------------------------------------------- random scoreboards
  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int RN  = (g == 0) ? 1 : (g == 1) ? 3 : 8;
    localparam int RLW = (RN > 1) ? $clog2(RN) : 1;

    logic             r_in_valid;
    logic [RN-1:0][7:0] r_in_data;
    logic [RN-1:0]    r_in_mask;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [7:0]       r_out_data;
    logic [RLW-1:0]   r_out_idx;
    logic             r_out_last;
    logic             r_out_ready;
    logic             done = 1'b0;
    logic [16:0]      exp_q[$];

    vx_serializer #(.DATAW(8), .N(RN)) u_rdut (
      .clk       (clk),
      .reset     (rst),
      .in_valid  (r_in_valid),
      .in_data   (r_in_data),
      .in_mask   (r_in_mask),
      .in_ready  (r_in_ready),
      .out_valid (r_out_valid),
      .out_data  (r_out_data),
      .out_idx   (r_out_idx),
      .out_last  (r_out_last),
      .out_ready (r_out_ready)
    );

    // Bundle driver: holds each bundle until accepted, then drains.
    initial begin
      logic fired;
      r_in_valid = 1'b0;
      r_in_data  = '0;
      r_in_mask  = '0;
      wait (rand_go);
      tick();
      for (int b = 0; b < 40; b++) begin
        for (int l = 0; l < RN; l++) r_in_data[l] = 8'($urandom_range(0, 255));
        r_in_mask  = RN'($urandom());
        r_in_valid = 1'b1;
        fired = 1'b0;
        for (int c = 0; c < 200 && !fired; c++) begin
          @(negedge clk);
          if (r_in_ready) fired = 1'b1;
          tick();
        end
        check($sformatf("r%0d.accept", RN), 32'(fired), 32'd1);
        r_in_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) tick();
      end
      for (int c = 0; c < 500 && (exp_q.size() != 0 || r_out_valid); c++) tick();
      check($sformatf("r%0d.drained", RN), 32'(exp_q.size()), 32'd0);
      done = 1'b1;
    end

    // Random consumer backpressure.
    initial begin
      r_out_ready = 1'b0;
      wait (rand_go);
      while (!done) begin
        r_out_ready = 1'($urandom_range(0, 1));
        tick();
      end
    end

    // Scoreboard: expected {last, idx, data} per active lane, ascending.
    always @(negedge clk) begin
      logic [16:0] e;
      if (!rst && rand_go) begin
        if (r_out_valid && r_out_ready) begin
          check($sformatf("r%0d.expected_beat", RN), 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("r%0d.beat", RN), 32'({r_out_last, 8'(r_out_idx), r_out_data}),
                  32'(e));
          end
        end
        if (r_in_valid && r_in_ready) begin
          for (int l = 0; l < RN; l++) begin
            if (r_in_mask[l]) begin
              exp_q.push_back({((r_in_mask >> (l + 1)) == '0), 8'(l), r_in_data[l]});
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- directed sequence
  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_mask   = '0;
    out_ready = 1'b0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset.valid",    32'(out_valid), 32'd0);
    check("reset.last",     32'(out_last),  32'd0);
    check("reset.in_ready", 32'(in_ready),  32'd1);
    tick();

    // Full mask
    in_valid = 1'b1; in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_mask = 4'b1111; out_ready = 1'b1;
    @(negedge clk);
    check("full.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk); expect_beat("full.b0", 8'h11, 2'd0, 1'b0); tick();
    @(negedge clk); expect_beat("full.b1", 8'h22, 2'd1, 1'b0); tick();
    @(negedge clk); expect_beat("full.b2", 8'h33, 2'd2, 1'b0); tick();
    @(negedge clk); expect_beat("full.b3", 8'h44, 2'd3, 1'b1); tick();
    @(negedge clk); expect_idle("full.end"); tick();

    // Sparse mask
    in_valid = 1'b1; in_mask = 4'b1010;
    tick();
    in_valid = 1'b0;
    @(negedge clk); expect_beat("sparse.b0", 8'h22, 2'd1, 1'b0); tick();
    @(negedge clk); expect_beat("sparse.b1", 8'h44, 2'd3, 1'b1); tick();
    @(negedge clk); expect_idle("sparse.end"); tick();

    // Back-to-back bundles with backpressure on the first beat
    in_valid = 1'b1; in_data = {8'h00, 8'h00, 8'hA1, 8'hA0}; in_mask = 4'b0011;
    tick();
    in_data = {8'h00, 8'h00, 8'hB1, 8'hB0}; out_ready = 1'b0;
    @(negedge clk); expect_beat("bp.stall0", 8'hA0, 2'd0, 1'b0);
    check("bp.stall0.in_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk); expect_beat("bp.stall1", 8'hA0, 2'd0, 1'b0); tick();
    out_ready = 1'b1;
    @(negedge clk); expect_beat("bp.a0", 8'hA0, 2'd0, 1'b0);
    check("bp.a0.in_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk); expect_beat("bp.a1", 8'hA1, 2'd1, 1'b1);
    check("bp.a1.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk); expect_beat("bp.b0", 8'hB0, 2'd0, 1'b0); tick();
    @(negedge clk); expect_beat("bp.b1", 8'hB1, 2'd1, 1'b1); tick();
    @(negedge clk); expect_idle("bp.end"); tick();

    // Zero mask followed by a single-lane bundle
    in_valid = 1'b1; in_data = {8'h00, 8'h00, 8'h00, 8'h77}; in_mask = 4'b0000;
    @(negedge clk); check("zero.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_data = {8'h00, 8'h00, 8'h00, 8'h5A}; in_mask = 4'b0001;
    @(negedge clk); expect_idle("zero.after");
    tick();
    in_valid = 1'b0;
    @(negedge clk); expect_beat("zero.one", 8'h5A, 2'd0, 1'b1); tick();
    @(negedge clk); expect_idle("zero.end"); tick();

    // Reset mid-bundle, with a simultaneous input and output fire
    in_valid = 1'b1; in_data = {8'h44, 8'h33, 8'h22, 8'h11}; in_mask = 4'b1111;
    tick();
    in_valid = 1'b0;
    @(negedge clk); expect_beat("rst.b0", 8'h11, 2'd0, 1'b0); tick();
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk); expect_idle("rst.after"); tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check($sformatf("rst.stale%0d", k), 32'(out_valid), 32'd0); tick();
    end

    // Random scoreboard runs at N=1,3,8
    rand_go = 1'b1;
    for (int c = 0; c < 20000 && !(g_rand[0].done && g_rand[1].done && g_rand[2].done); c++) tick();
    check("rand.complete", 32'({g_rand[0].done, g_rand[1].done, g_rand[2].done}), 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_serializer.md
VX_SERIALIZER -- requirements
Module: VX_serializer

Interface
REQ-001 SHALL have parameter DATAW, default 1, meaning width of one lane word in bits.
REQ-002 SHALL have parameter N, default 4, meaning number of lanes per parallel input; legal range 1..64.
REQ-003 SHALL have parameter LANEW, default $clog2(N) with a minimum of 1, meaning width of the lane index output.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning a parallel input bundle is offered.
REQ-007 SHALL have port in_data, input, [N-1:0][DATAW-1:0], meaning the lane words.
REQ-008 SHALL have port in_mask, input, N bits, meaning the active lanes to emit.
REQ-009 SHALL have port in_ready, output, 1 bit, meaning the bundle is accepted this cycle.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning a serial beat is presented.
REQ-011 SHALL have port out_data, output, DATAW bits, meaning the current lane word.
REQ-012 SHALL have port out_idx, output, LANEW bits, meaning the lane number of out_data.
REQ-013 SHALL have port out_last, output, 1 bit, meaning the current beat is the final active lane of its bundle.
REQ-014 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the beat.

Function
REQ-015 SHALL accept a bundle (input fire) when in_valid and in_ready are both high in the same cycle, and produce an output beat (output fire) when out_valid and out_ready are both high in the same cycle.
REQ-016 SHALL on input fire register in_data and in_mask into a pending data register and a pending mask register.
REQ-017 SHALL drive out_valid = OR of the pending mask bits, taken directly from registers.
REQ-018 SHALL drive out_idx = index of the lowest set bit of the pending mask, out_data = the pending word at that index, and out_last = 1 exactly when one pending bit remains.
REQ-019 SHALL have a latency of one cycle: a bundle accepted in cycle t gives its first out_valid in cycle t+1.
REQ-020 SHALL emit lanes in ascending index order, one per output fire, and skip masked-off lanes with no bubble cycles.
REQ-021 SHALL on output fire clear the lowest set pending bit.
REQ-022 SHALL drive in_ready = !out_valid OR (out_ready AND out_last), so the next bundle loads in the same cycle the last beat fires with zero bubble.
REQ-023 SHALL hold out_data, out_idx and out_last stable while out_valid is high and out_ready is low.
REQ-024 SHALL on input fire with in_mask == 0 consume the bundle, produce no output beat, and leave in_ready high the next cycle.
REQ-025 SHALL for N = 1 present each active bundle as one beat with out_idx = 0 and out_last = 1.
REQ-026 SHALL ignore in_data and in_mask whenever there is no input fire.
REQ-027 SHALL require the producer to hold in_valid and in_data stable until input fire; that stability is checked by the verification bench, not by this block.

Reset
REQ-028 SHALL clear the pending mask on reset, giving out_valid = 0, out_last = 0 and in_ready = 1 in the first cycle after reset.
REQ-029 SHALL leave the pending data register un-reset; out_data and out_idx are don't-care while out_valid is low.
REQ-030 SHALL on reset asserted mid-bundle discard all remaining beats with no partial emission after reset is released.
REQ-031 SHALL give reset priority over a simultaneous input fire or output fire.

Verification
REQ-032 SHALL cover the full mask case: N=4, DATAW=8, in_mask=4'b1111, data {D3..D0}={0x44,0x33,0x22,0x11}, out_ready=1 -> beats 0x11/idx0, 0x22/idx1, 0x33/idx2, 0x44/idx3 in cycles t+1..t+4, out_last only on idx3.
REQ-033 SHALL cover the sparse mask case: in_mask=4'b1010 -> exactly 2 beats, idx1 then idx3, with out_last on idx3, back-to-back.
REQ-034 SHALL cover back-to-back bundles with backpressure: two bundles, mask 4'b0011 each, with out_ready low for 2 cycles on the first beat -> beat held stable, second bundle accepted in the cycle the first bundle's last beat fires, and no gap between bundles.
REQ-035 SHALL cover the zero mask case: in_mask=0 then in_mask=4'b0001 -> the first bundle produces no beat and the second produces a single beat idx0 with out_last=1.
REQ-036 SHALL cover reset mid-bundle: reset asserted after 1 of 4 beats -> out_valid=0 and in_ready=1 the next cycle, and no stale beats after reset is released.
REQ-037 SHALL cover a random scoreboard run: random masks and random out_ready at N=1, 3 and 8 -> output order equals the set lanes of each bundle in ascending order, with no loss or duplication.
